md_unit: RTL



---
 rtl/md_pkg.sv | 19 +
 rtl/md_negate.sv | 14 +
 rtl/md_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared state encoding, op-field encodings and default width for the md_unit
// multiply/divide engine.
package md_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // op[0] selects the operation, op[1] selects unsigned operands.
  localparam int   OP_KIND_BIT     = 0;
  localparam int   OP_UNSIGNED_BIT = 1;
  localparam logic OP_MULT         = 1'b0;
  localparam logic OP_DIV          = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/md_negate.sv
// Two's-complement conditional negate: result = negate ? -value : value.
module md_negate
  import md_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/md_unit.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle. Define MD_UNIT_UNSIGNED_EN to honour op[1].
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic             is_div_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic [WIDTH-1:0] operand_q;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] count;

  logic is_signed;
`ifdef MD_UNIT_UNSIGNED_EN
  assign is_signed = ~op[OP_UNSIGNED_BIT];
`else
  logic unused_op_bit;
  assign unused_op_bit = op[OP_UNSIGNED_BIT];
  assign is_signed     = 1'b1;
`endif

  logic             sign_a, sign_b, is_div_in, zero_div;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a    = is_signed & a[WIDTH-1];
  assign sign_b    = is_signed & b[WIDTH-1];
  assign is_div_in = (op[OP_KIND_BIT] == OP_DIV);
  assign zero_div  = is_div_in && (b == '0);

  md_negate #(.WIDTH(WIDTH)) u_mag_a (.value(a), .negate(sign_a), .result(mag_a));
  md_negate #(.WIDTH(WIDTH)) u_mag_b (.value(b), .negate(sign_b), .result(mag_b));

  always_comb begin
    // NOTE: next_state gets a default before the case so no path infers a latch.
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = zero_div ? DONE : CALC;
      CALC:    if (count == LAST_ITER) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One iteration of either algorithm; the divide trial needs one extra bit for its sign.
  logic [WIDTH:0]   sum, shifted, trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, operand_q};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, operand_q};
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (is_div_q) begin
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end else if (acc_lo[0]) begin
      {step_hi, step_lo} = {sum, acc_lo[WIDTH-1:1]};
    end else begin
      {step_hi, step_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up is applied to the final iteration's output as it is registered.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  md_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value({step_hi, step_lo}), .negate(res_neg_q), .result(prod_fixed)
  );
  md_negate #(.WIDTH(WIDTH)) u_fix_quo (.value(step_lo), .negate(res_neg_q), .result(quo_fixed));
  md_negate #(.WIDTH(WIDTH)) u_fix_rem (.value(step_hi), .negate(rem_neg_q), .result(rem_fixed));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      count     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      done  <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          is_div_q  <= is_div_in;
          res_neg_q <= sign_a ^ sign_b;
          rem_neg_q <= sign_a;
          count     <= '0;
          acc_hi    <= '0;
          acc_lo    <= is_div_in ? mag_a : mag_b;
          operand_q <= is_div_in ? mag_b : mag_a;
          if (zero_div) div_zero <= 1'b1;
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            hi       <= is_div_q ? rem_fixed : prod_fixed[2*WIDTH-1:WIDTH];
            lo       <= is_div_q ? quo_fixed : prod_fixed[WIDTH-1:0];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
